exec_ctrl_unit: RTL and testbench

Decode-and-execute core of the single-cycle RV32I-subset processor. Combines three functions:
- main control decoder: instruction → datapath control signals plus a 4-bit ALUOp
- ALU control mapper: 4-bit ALUOp → 6-bit ALU control word
- 32-bit integer ALU with zero flag
Sits between the register file / operand mux and the data memory / writeback mux. Also holds a small registered status (sticky illegal-instruction flag, registered zero flag).

---
 rtl/exec_ctrl_pkg.sv | 72 +++++++
 rtl/exec_ctrl_unit_alu_core.sv | 60 ++++++
 rtl/exec_ctrl_unit.sv | 170 +++++++++++++++++
 tb/tb_exec_ctrl_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the decode/execute core: opcodes, ALUOp codes,
// ALU function codes and the ALU control-word layout.
package exec_ctrl_pkg;

    localparam int DATA_W = 32;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALUOP_ADD   = 4'd0,
        ALUOP_SUB   = 4'd1,
        ALUOP_SLL   = 4'd2,
        ALUOP_SLT   = 4'd3,
        ALUOP_SLTU  = 4'd4,
        ALUOP_XOR   = 4'd5,
        ALUOP_SRL   = 4'd6,
        ALUOP_SRA   = 4'd7,
        ALUOP_OR    = 4'd8,
        ALUOP_AND   = 4'd9,
        ALUOP_SEQ   = 4'd10,
        ALUOP_SGE   = 4'd11,
        ALUOP_SGEU  = 4'd12,
        ALUOP_RSV13 = 4'd13,
        ALUOP_RSV14 = 4'd14,
        ALUOP_RSV15 = 4'd15
    } aluop_e;

    // ALU function field, ctrl[3:0]
    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SLL  = 4'd1;
    localparam logic [3:0] FN_SLT  = 4'd2;
    localparam logic [3:0] FN_SLTU = 4'd3;
    localparam logic [3:0] FN_XOR  = 4'd4;
    localparam logic [3:0] FN_SRL  = 4'd5;
    localparam logic [3:0] FN_SRA  = 4'd6;
    localparam logic [3:0] FN_OR   = 4'd7;
    localparam logic [3:0] FN_AND  = 4'd8;
    localparam logic [3:0] FN_EQ   = 4'd9;

    localparam int CTRL_SUB_BIT = 4;
    localparam int CTRL_INV_BIT = 5;

    // Map an ALUOp to the 6-bit ALU control word {invert, subtract, function}.
    function automatic logic [5:0] aluop_to_ctrl(input aluop_e op);
        logic [5:0] ctrl;
        case (op)
            ALUOP_ADD:  ctrl = {1'b0, 1'b0, FN_ADD};
            ALUOP_SUB:  ctrl = {1'b0, 1'b1, FN_ADD};
            ALUOP_SLL:  ctrl = {1'b0, 1'b0, FN_SLL};
            ALUOP_SLT:  ctrl = {1'b0, 1'b0, FN_SLT};
            ALUOP_SLTU: ctrl = {1'b0, 1'b0, FN_SLTU};
            ALUOP_XOR:  ctrl = {1'b0, 1'b0, FN_XOR};
            ALUOP_SRL:  ctrl = {1'b0, 1'b0, FN_SRL};
            ALUOP_SRA:  ctrl = {1'b0, 1'b0, FN_SRA};
            ALUOP_OR:   ctrl = {1'b0, 1'b0, FN_OR};
            ALUOP_AND:  ctrl = {1'b0, 1'b0, FN_AND};
            ALUOP_SEQ:  ctrl = {1'b0, 1'b0, FN_EQ};
            ALUOP_SGE:  ctrl = {1'b1, 1'b0, FN_SLT};
            ALUOP_SGEU: ctrl = {1'b1, 1'b0, FN_SLTU};
            default:    ctrl = {1'b0, 1'b0, FN_ADD};
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/exec_ctrl_unit_alu_core.sv
// Combinational integer ALU driven by the 6-bit control word; also flags a zero result.
module alu_core
    import exec_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [5:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONE_W  = {{(XLEN-1){1'b0}}, 1'b1};

    logic [3:0]      fn_s;
    logic            sub_s;
    logic            inv_s;
    logic [4:0]      shamt_s;
    logic [XLEN-1:0] b_eff_s;
    logic            cmp_s;

    assign fn_s    = ctrl[3:0];
    assign sub_s   = ctrl[CTRL_SUB_BIT];
    assign inv_s   = ctrl[CTRL_INV_BIT];
    assign shamt_s = b[4:0];

    // Select the function; compares return 0/1, optionally inverted.
    always_comb begin
        result  = ZERO_W;
        cmp_s   = 1'b0;
        b_eff_s = sub_s ? (~b + ONE_W) : b;
        case (fn_s)
            FN_ADD:  result = a + b_eff_s;
            FN_SLL:  result = a << shamt_s;
            FN_SLT: begin
                cmp_s  = ($signed(a) < $signed(b));
                result = {{(XLEN-1){1'b0}}, cmp_s ^ inv_s};
            end
            FN_SLTU: begin
                cmp_s  = (a < b);
                result = {{(XLEN-1){1'b0}}, cmp_s ^ inv_s};
            end
            FN_XOR:  result = a ^ b;
            FN_SRL:  result = a >> shamt_s;
            FN_SRA:  result = $signed(a) >>> shamt_s;
            FN_OR:   result = a | b;
            FN_AND:  result = a & b;
            FN_EQ: begin
                cmp_s  = (a == b);
                result = {{(XLEN-1){1'b0}}, cmp_s ^ inv_s};
            end
            default: result = ZERO_W;
        endcase
    end

    assign zero = (result == ZERO_W);

endmodule

// File: rtl/exec_ctrl_unit.sv
// Decode-and-execute core: main decoder, ALUOp mapping, ALU and status flops.
module exec_ctrl_unit
    import exec_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] op2_data_i,
    output logic            branch_o,
    output logic            memread_o,
    output logic            memtoreg_o,
    output logic            memwrite_o,
    output logic            alusrc_o,
    output logic            regwrite_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic            zero_o,
    output logic            illegal_o,
    output logic            zero_q_o,
    output logic            illegal_sticky_o
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    aluop_e     aluop_s;
    logic [5:0] alu_ctrl_s;
    logic       branch_s, memread_s, memtoreg_s, memwrite_s, alusrc_s, regwrite_s;
    logic       illegal_s;
    logic       zero_q_r;
    logic       illegal_sticky_r;
    logic       unused_inst_s;

    assign opcode_s      = inst_i[6:0];
    assign funct3_s      = inst_i[14:12];
    assign funct7_s      = inst_i[31:25];
    assign unused_inst_s = ^{inst_i[24:15], inst_i[11:7]};

    // Main decoder; unsupported encodings leave every control low and ALUOp at ADD.
    always_comb begin
        branch_s   = 1'b0;
        memread_s  = 1'b0;
        memtoreg_s = 1'b0;
        memwrite_s = 1'b0;
        alusrc_s   = 1'b0;
        regwrite_s = 1'b0;
        illegal_s  = 1'b0;
        aluop_s    = ALUOP_ADD;
        case (opcode_s)
            OPC_RTYPE: begin
                if (funct7_s == F7_BASE) begin
                    regwrite_s = 1'b1;
                    case (funct3_s)
                        3'b000:  aluop_s = ALUOP_ADD;
                        3'b001:  aluop_s = ALUOP_SLL;
                        3'b010:  aluop_s = ALUOP_SLT;
                        3'b011:  aluop_s = ALUOP_SLTU;
                        3'b100:  aluop_s = ALUOP_XOR;
                        3'b101:  aluop_s = ALUOP_SRL;
                        3'b110:  aluop_s = ALUOP_OR;
                        default: aluop_s = ALUOP_AND;
                    endcase
                end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b000)) begin
                    regwrite_s = 1'b1;
                    aluop_s    = ALUOP_SUB;
                end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b101)) begin
                    regwrite_s = 1'b1;
                    aluop_s    = ALUOP_SRA;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_IALU: begin
                case (funct3_s)
                    3'b000:  aluop_s = ALUOP_ADD;
                    3'b010:  aluop_s = ALUOP_SLT;
                    3'b011:  aluop_s = ALUOP_SLTU;
                    3'b100:  aluop_s = ALUOP_XOR;
                    3'b110:  aluop_s = ALUOP_OR;
                    3'b111:  aluop_s = ALUOP_AND;
                    3'b001: begin
                        if (funct7_s == F7_BASE) aluop_s = ALUOP_SLL;
                        else                     illegal_s = 1'b1;
                    end
                    default: begin
                        if (funct7_s == F7_BASE)     aluop_s = ALUOP_SRL;
                        else if (funct7_s == F7_ALT) aluop_s = ALUOP_SRA;
                        else                         illegal_s = 1'b1;
                    end
                endcase
                if (!illegal_s) begin
                    regwrite_s = 1'b1;
                    alusrc_s   = 1'b1;
                end else begin
                    aluop_s = ALUOP_ADD;
                end
            end
            OPC_LOAD: begin
                if (funct3_s == 3'b010) begin
                    memread_s  = 1'b1;
                    memtoreg_s = 1'b1;
                    regwrite_s = 1'b1;
                    alusrc_s   = 1'b1;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3_s == 3'b010) begin
                    memwrite_s = 1'b1;
                    alusrc_s   = 1'b1;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_BRANCH: begin
                // ALU op chosen so that a zero result means the branch is taken.
                branch_s = 1'b1;
                case (funct3_s)
                    3'b000:  aluop_s = ALUOP_SUB;
                    3'b001:  aluop_s = ALUOP_SEQ;
                    3'b100:  aluop_s = ALUOP_SGE;
                    3'b101:  aluop_s = ALUOP_SLT;
                    3'b110:  aluop_s = ALUOP_SGEU;
                    3'b111:  aluop_s = ALUOP_SLTU;
                    default: begin
                        branch_s  = 1'b0;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            default: illegal_s = 1'b1;
        endcase
    end

    assign alu_ctrl_s = aluop_to_ctrl(aluop_s);

    assign branch_o   = branch_s;
    assign memread_o  = memread_s;
    assign memtoreg_o = memtoreg_s;
    assign memwrite_o = memwrite_s;
    assign alusrc_o   = alusrc_s;
    assign regwrite_o = regwrite_s;
    assign illegal_o  = illegal_s;

    alu_core #(.XLEN(XLEN)) u_alu (
        .a      (rs1_data_i),
        .b      (op2_data_i),
        .ctrl   (alu_ctrl_s),
        .result (alu_result_o),
        .zero   (zero_o)
    );

    // Status flops: zero flag sampled every edge, illegal flag sticky until reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            zero_q_r         <= 1'b0;
            illegal_sticky_r <= 1'b0;
        end else begin
            zero_q_r         <= zero_o;
            illegal_sticky_r <= illegal_sticky_r | illegal_s;
        end
    end

    assign zero_q_o         = zero_q_r;
    assign illegal_sticky_o = illegal_sticky_r;

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Self-checking bench for exec_ctrl_unit using a queue-based scoreboard.
module tb_exec_ctrl_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] inst_i, rs1_data_i, op2_data_i;
    logic        branch_o, memread_o, memtoreg_o, memwrite_o, alusrc_o, regwrite_o;
    logic [31:0] alu_result_o;
    logic        zero_o, illegal_o, zero_q_o, illegal_sticky_o;
    logic [5:0]  ctrl_obs;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  ctrl;
        logic [31:0] res;
        logic        z;
        logic        ill;
    } vec_t;

    vec_t sb_q[$];

    exec_ctrl_unit #(.XLEN(32)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .inst_i           (inst_i),
        .rs1_data_i       (rs1_data_i),
        .op2_data_i       (op2_data_i),
        .branch_o         (branch_o),
        .memread_o        (memread_o),
        .memtoreg_o       (memtoreg_o),
        .memwrite_o       (memwrite_o),
        .alusrc_o         (alusrc_o),
        .regwrite_o       (regwrite_o),
        .alu_result_o     (alu_result_o),
        .zero_o           (zero_o),
        .illegal_o        (illegal_o),
        .zero_q_o         (zero_q_o),
        .illegal_sticky_o (illegal_sticky_o)
    );

    always #5 clk_i = ~clk_i;

    // {branch, memread, memtoreg, memwrite, alusrc, regwrite}
    assign ctrl_obs = {branch_o, memread_o, memtoreg_o, memwrite_o, alusrc_o, regwrite_o};

    function automatic vec_t mk(input string name, input logic [31:0] inst, input logic [31:0] a,
                                input logic [31:0] b, input logic [5:0] ctrl, input logic [31:0] res,
                                input logic z, input logic ill);
        vec_t v;
        v.name = name; v.inst = inst; v.a = a; v.b = b;
        v.ctrl = ctrl; v.res = res; v.z = z; v.ill = ill;
        return v;
    endfunction

    // Independent RV32I reference for R-type operations.
    function automatic logic [31:0] ref_r(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0: r = alt ? (a - b) : (a + b);
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        rst_i = 1'b0; inst_i = 32'h0; rs1_data_i = 32'h0; op2_data_i = 32'h0;
        #3;
        n_cmp++;
        if ({zero_q_o, illegal_sticky_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flops got %b want 00", {zero_q_o, illegal_sticky_o});
        end
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++;
        if ({zero_q_o, illegal_sticky_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_held got %b want 00", {zero_q_o, illegal_sticky_o});
        end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_decode_vectors();
        vec_t tbl[$];
        vec_t e;
        tbl.push_back(mk("add",       32'h002081B3, 32'd7,        32'd5,        6'b000001, 32'd12,       1'b0, 1'b0));
        tbl.push_back(mk("sub",       32'h402081B3, 32'd5,        32'd5,        6'b000001, 32'd0,        1'b1, 1'b0));
        tbl.push_back(mk("srai",      32'h4030D193, 32'h80000000, 32'd3,        6'b000011, 32'hF0000000, 1'b0, 1'b0));
        tbl.push_back(mk("srli",      32'h0030D193, 32'h80000000, 32'd3,        6'b000011, 32'h10000000, 1'b0, 1'b0));
        tbl.push_back(mk("lw",        32'h0040A183, 32'h100,      32'd4,        6'b011011, 32'h104,      1'b0, 1'b0));
        tbl.push_back(mk("sw",        32'h0020A223, 32'h100,      32'd4,        6'b000110, 32'h104,      1'b0, 1'b0));
        tbl.push_back(mk("bne_nt",    32'h00209463, 32'd3,        32'd3,        6'b100000, 32'd1,        1'b0, 1'b0));
        tbl.push_back(mk("bne_t",     32'h00209463, 32'd3,        32'd4,        6'b100000, 32'd0,        1'b1, 1'b0));
        tbl.push_back(mk("beq_t",     32'h00208463, 32'd9,        32'd9,        6'b100000, 32'd0,        1'b1, 1'b0));
        tbl.push_back(mk("blt",       32'h0020C463, 32'hFFFFFFFF, 32'd0,        6'b100000, 32'd0,        1'b1, 1'b0));
        tbl.push_back(mk("bltu",      32'h0020E463, 32'hFFFFFFFF, 32'd0,        6'b100000, 32'd1,        1'b0, 1'b0));
        tbl.push_back(mk("bge",       32'h0020D463, 32'hFFFFFFFF, 32'd0,        6'b100000, 32'd1,        1'b0, 1'b0));
        tbl.push_back(mk("bgeu",      32'h0020F463, 32'hFFFFFFFF, 32'd0,        6'b100000, 32'd0,        1'b1, 1'b0));
        tbl.push_back(mk("slti",      32'hFFF0A193, 32'd5,        32'hFFFFFFFF, 6'b000011, 32'd0,        1'b1, 1'b0));
        tbl.push_back(mk("sltiu",     32'hFFF0B193, 32'd5,        32'hFFFFFFFF, 6'b000011, 32'd1,        1'b0, 1'b0));
        tbl.push_back(mk("xor",       32'h0020C1B3, 32'hF0F0F0F0, 32'hFF00FF00, 6'b000001, 32'h0FF00FF0, 1'b0, 1'b0));
        tbl.push_back(mk("sll_shamt", 32'h002091B3, 32'd1,        32'h21,       6'b000001, 32'd2,        1'b0, 1'b0));
        tbl.push_back(mk("ill_ones",  32'hFFFFFFFF, 32'd1,        32'd2,        6'b000000, 32'd3,        1'b0, 1'b1));
        tbl.push_back(mk("ill_zero",  32'h00000000, 32'd0,        32'd0,        6'b000000, 32'd0,        1'b1, 1'b1));
        tbl.push_back(mk("ill_rf7",   32'h402091B3, 32'd1,        32'd1,        6'b000000, 32'd2,        1'b0, 1'b1));
        tbl.push_back(mk("ill_br010", 32'h0020A463, 32'd3,        32'd3,        6'b000000, 32'd6,        1'b0, 1'b1));
        tbl.push_back(mk("ill_lb",    32'h00408183, 32'h100,      32'd4,        6'b000000, 32'h104,      1'b0, 1'b1));
        tbl.push_back(mk("ill_slli",  32'h40109193, 32'd1,        32'd1,        6'b000000, 32'd2,        1'b0, 1'b1));
        tbl.push_back(mk("ill_srli",  32'h0210D193, 32'd8,        32'd1,        6'b000000, 32'd9,        1'b0, 1'b1));
        foreach (tbl[i]) begin
            @(posedge clk_i);
            #1;
            inst_i = tbl[i].inst; rs1_data_i = tbl[i].a; op2_data_i = tbl[i].b;
            sb_q.push_back(tbl[i]);
            @(negedge clk_i);
            e = sb_q.pop_front();
            n_cmp++;
            if (ctrl_obs !== e.ctrl) begin
                n_fail++; $display("FAIL %s ctrl got %b want %b", e.name, ctrl_obs, e.ctrl);
            end
            n_cmp++;
            if (alu_result_o !== e.res) begin
                n_fail++; $display("FAIL %s result got %h want %h", e.name, alu_result_o, e.res);
            end
            n_cmp++;
            if (zero_o !== e.z) begin
                n_fail++; $display("FAIL %s zero got %b want %b", e.name, zero_o, e.z);
            end
            n_cmp++;
            if (illegal_o !== e.ill) begin
                n_fail++; $display("FAIL %s illegal got %b want %b", e.name, illegal_o, e.ill);
            end
        end
    endtask

    task automatic test_zero_q();
        @(posedge clk_i);
        #1;
        inst_i = 32'h402081B3; rs1_data_i = 32'd5; op2_data_i = 32'd5;
        @(posedge clk_i);
        #1;
        n_cmp++;
        if (zero_q_o !== 1'b1) begin
            n_fail++; $display("FAIL zero_q_set got %b want 1", zero_q_o);
        end
        inst_i = 32'h002081B3; rs1_data_i = 32'd7; op2_data_i = 32'd5;
        @(posedge clk_i);
        #1;
        n_cmp++;
        if (zero_q_o !== 1'b0) begin
            n_fail++; $display("FAIL zero_q_clr got %b want 0", zero_q_o);
        end
    endtask

    task automatic test_illegal_sticky();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        inst_i = 32'h002081B3; rs1_data_i = 32'd7; op2_data_i = 32'd5;
        #1;
        n_cmp++;
        if (illegal_sticky_o !== 1'b0) begin
            n_fail++; $display("FAIL sticky_pre got %b want 0", illegal_sticky_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        n_cmp++;
        if (illegal_sticky_o !== 1'b0) begin
            n_fail++; $display("FAIL sticky_legal got %b want 0", illegal_sticky_o);
        end
        inst_i = 32'hFFFFFFFF; rs1_data_i = 32'd0; op2_data_i = 32'd0;
        @(posedge clk_i);
        #1;
        n_cmp++;
        if ({illegal_sticky_o, zero_q_o} !== 2'b11) begin
            n_fail++; $display("FAIL sticky_set got %b want 11", {illegal_sticky_o, zero_q_o});
        end
        inst_i = 32'h002081B3; rs1_data_i = 32'd7; op2_data_i = 32'd5;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            n_cmp++;
            if (illegal_sticky_o !== 1'b1) begin
                n_fail++; $display("FAIL sticky_hold%0d got %b want 1", k, illegal_sticky_o);
            end
        end
        // Reset between edges: flops clear at once, combinational path untouched.
        #1;
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if ({illegal_sticky_o, zero_q_o} !== 2'b00) begin
            n_fail++; $display("FAIL midrst_flops got %b want 00", {illegal_sticky_o, zero_q_o});
        end
        n_cmp++;
        if ({alu_result_o, regwrite_o} !== {32'd12, 1'b1}) begin
            n_fail++; $display("FAIL midrst_comb got %h/%b want 0000000c/1", alu_result_o, regwrite_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        vec_t e;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] a, b;
        logic        prev_z;
        logic        have_prev;
        have_prev = 1'b0;
        prev_z    = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk_i);
            #1;
            if (have_prev) begin
                n_cmp++;
                if (zero_q_o !== prev_z) begin
                    n_fail++; $display("FAIL b2b_zero_q[%0d] got %b want %b", n, zero_q_o, prev_z);
                end
            end
            f3  = 3'($urandom_range(0, 7));
            alt = ((f3 == 3'd0) || (f3 == 3'd5)) ? 1'($urandom_range(0, 1)) : 1'b0;
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            inst_i = {1'b0, alt, 5'd0, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
            rs1_data_i = a; op2_data_i = b;
            e = mk("b2b", inst_i, a, b, 6'b000001, ref_r(f3, alt, a, b), 1'b0, 1'b0);
            e.z = (e.res == 32'd0);
            sb_q.push_back(e);
            @(negedge clk_i);
            e = sb_q.pop_front();
            n_cmp++;
            if ({ctrl_obs, illegal_o} !== {e.ctrl, e.ill}) begin
                n_fail++; $display("FAIL b2b_ctrl[%0d] got %b want %b", n, {ctrl_obs, illegal_o}, {e.ctrl, e.ill});
            end
            n_cmp++;
            if ({alu_result_o, zero_o} !== {e.res, e.z}) begin
                n_fail++; $display("FAIL b2b_result[%0d] inst %h got %h/%b want %h/%b", n, e.inst, alu_result_o, zero_o, e.res, e.z);
            end
            prev_z    = e.z;
            have_prev = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_decode_vectors();
        test_zero_q();
        test_illegal_sticky();
        test_back_to_back();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_left got %0d want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
